// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - round-robin frame arbiter for the shared RMII transmit dibit path
module eth_tx_arbiter #(
    parameter int PRE_DIBITS = 32,
    parameter int IFG_DIBITS = 48,
    parameter int MAX_DIBITS = 6072
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [1:0] axiid0,
    input  logic       axiiv0,
    input  logic       last0,
    output logic       grant0,
    output logic       ready0,
    input  logic       req1,
    input  logic [1:0] axiid1,
    input  logic       axiiv1,
    input  logic       last1,
    output logic       grant1,
    output logic       ready1,
    output logic [1:0] axiod,
    output logic       axiov,
    output logic       abort
);

    localparam int CW = 13;
    localparam logic [CW-1:0] PRE_END = CW'(PRE_DIBITS - 1);
    localparam logic [CW-1:0] IFG_END = CW'(IFG_DIBITS - 1);
    localparam logic [CW-1:0] MAX_END = CW'(MAX_DIBITS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            last_served;
    logic            sel_iv;
    logic            sel_last;
    logic [1:0]      sel_d;

    // last_served always names the owner of the frame in flight
    always_comb begin
        sel_iv   = last_served ? axiiv1 : axiiv0;
        sel_last = last_served ? last1  : last0;
        sel_d    = last_served ? axiid1 : axiid0;
    end

    // frame sequencer: arbitration, preamble/SFD, payload forwarding, inter-frame gap
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            last_served <= 1'b1;
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            ready0      <= 1'b0;
            ready1      <= 1'b0;
            axiod       <= 2'b00;
            axiov       <= 1'b0;
            abort       <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    axiov <= 1'b0;
                    axiod <= 2'b00;
                    // on a tie the source that was not served last wins
                    if (req0 && (!req1 || last_served)) begin
                        grant0      <= 1'b1;
                        last_served <= 1'b0;
                        state       <= PREAMBLE;
                        count       <= '0;
                    end else if (req1) begin
                        grant1      <= 1'b1;
                        last_served <= 1'b1;
                        state       <= PREAMBLE;
                        count       <= '0;
                    end
                end
                PREAMBLE: begin
                    axiov <= 1'b1;
                    if (count == PRE_END) begin
                        // SFD 0xD5 ends with dibit 11 when sent LSB-first
                        axiod  <= 2'b11;
                        state  <= PAYLOAD;
                        count  <= '0;
                        ready0 <= ~last_served;
                        ready1 <= last_served;
                    end else begin
                        axiod <= 2'b01;
                        count <= count + 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (sel_iv) begin
                        axiov <= 1'b1;
                        axiod <= sel_d;
                        count <= count + 1'b1;
                        if (sel_last || count == MAX_END) begin
                            abort  <= ~sel_last;
                            grant0 <= 1'b0;
                            grant1 <= 1'b0;
                            ready0 <= 1'b0;
                            ready1 <= 1'b0;
                            state  <= GAP;
                            count  <= '0;
                        end
                    end else begin
                        // underrun: a granted source must stream back-to-back
                        axiov  <= 1'b0;
                        axiod  <= 2'b00;
                        abort  <= 1'b1;
                        grant0 <= 1'b0;
                        grant1 <= 1'b0;
                        ready0 <= 1'b0;
                        ready1 <= 1'b0;
                        state  <= GAP;
                        count  <= '0;
                    end
                end
                GAP: begin
                    axiov <= 1'b0;
                    axiod <= 2'b00;
                    if (count == IFG_END) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;

    localparam int PRE  = 32;
    localparam int IFG  = 48;
    localparam int MAXD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, axiiv0 = 1'b0, last0 = 1'b0;
    logic       req1 = 1'b0, axiiv1 = 1'b0, last1 = 1'b0;
    logic [1:0] axiid0 = 2'b00, axiid1 = 2'b00;
    logic       grant0, ready0, grant1, ready1, axiov, abort;
    logic [1:0] axiod;

    eth_tx_arbiter #(.PRE_DIBITS(PRE), .IFG_DIBITS(IFG), .MAX_DIBITS(MAXD)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .axiid0(axiid0), .axiiv0(axiiv0), .last0(last0),
        .grant0(grant0), .ready0(ready0),
        .req1(req1), .axiid1(axiid1), .axiiv1(axiiv1), .last1(last1),
        .grant1(grant1), .ready1(ready1),
        .axiod(axiod), .axiov(axiov), .abort(abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (timestamp based) ----------------
    int         cyc = 0;
    int         m_owner = -1;
    int         m_last = 1;
    int         m_gstart = 0;
    int         m_pay = 0;
    int         m_free = 0;
    logic       e_axiov = 0, e_abort = 0, e_g0 = 0, e_g1 = 0, e_r0 = 0, e_r1 = 0;
    logic [1:0] e_axiod = 0;

    // predicts the registered outputs from the rules: arbitration once free, preamble window, payload, gap
    always @(posedge clk) begin
        int t;
        int pick;
        bit iv;
        bit lst;
        logic [1:0] d;
        cyc <= cyc + 1;
        e_abort <= 1'b0;
        if (rst) begin
            m_owner <= -1;
            m_last  <= 1;
            m_free  <= cyc + 1;
            e_axiov <= 0; e_axiod <= 0; e_g0 <= 0; e_g1 <= 0; e_r0 <= 0; e_r1 <= 0;
        end else if (m_owner < 0) begin
            e_axiov <= 0; e_axiod <= 0; e_g0 <= 0; e_g1 <= 0; e_r0 <= 0; e_r1 <= 0;
            if (cyc >= m_free && (req0 || req1)) begin
                if (req0 && req1) pick = 1 - m_last;
                else pick = req0 ? 0 : 1;
                m_owner  <= pick;
                m_last   <= pick;
                m_gstart <= cyc;
                m_pay    <= 0;
                e_g0 <= (pick == 0);
                e_g1 <= (pick == 1);
            end
        end else begin
            t = cyc - m_gstart;
            if (t <= PRE) begin
                e_axiov <= 1;
                e_axiod <= (t == PRE) ? 2'd3 : 2'd1;
                e_r0 <= (t == PRE) && (m_owner == 0);
                e_r1 <= (t == PRE) && (m_owner == 1);
            end else begin
                iv  = (m_owner == 1) ? axiiv1 : axiiv0;
                lst = (m_owner == 1) ? last1 : last0;
                d   = (m_owner == 1) ? axiid1 : axiid0;
                if (iv) begin
                    e_axiov <= 1;
                    e_axiod <= d;
                    m_pay   <= m_pay + 1;
                    if (lst || m_pay + 1 >= MAXD) begin
                        e_abort <= !lst;
                        m_owner <= -1;
                        m_free  <= cyc + IFG + 1;
                        e_g0 <= 0; e_g1 <= 0; e_r0 <= 0; e_r1 <= 0;
                    end
                end else begin
                    e_axiov <= 0;
                    e_axiod <= 0;
                    e_abort <= 1;
                    m_owner <= -1;
                    m_free  <= cyc + IFG + 1;
                    e_g0 <= 0; e_g1 <= 0; e_r0 <= 0; e_r1 <= 0;
                end
            end
        end
    end

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("cyc_axiov",  axiov,  e_axiov);
                chk("cyc_axiod",  axiod,  e_axiod);
                chk("cyc_grant0", grant0, e_g0);
                chk("cyc_grant1", grant1, e_g1);
                chk("cyc_ready0", ready0, e_r0);
                chk("cyc_ready1", ready1, e_r1);
                chk("cyc_abort",  abort,  e_abort);
            end
        end
    end

    // ---------------- source drivers ----------------
    int nfr[2]  = '{0, 0};
    int len[2]  = '{0, 0};
    int drop[2] = '{-1, -1};
    int idx[2]  = '{0, 0};
    bit lastf[2] = '{1, 1};
    bit acc[2]  = '{0, 0};
    bit gp[2]   = '{0, 0};

    initial begin
        bit g, r, iv, l;
        logic [1:0] d;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                g = (s == 1) ? grant1 : grant0;
                r = (s == 1) ? ready1 : ready0;
                if (acc[s]) idx[s]++;
                if (g && !gp[s]) begin
                    idx[s] = 0;
                    if (nfr[s] > 0) nfr[s]--;
                end
                gp[s] = g;
                iv = g && (idx[s] < len[s]) && (idx[s] != drop[s]);
                d  = 2'((idx[s] + 2 * s + 1) & 3);
                l  = iv && lastf[s] && (idx[s] == len[s] - 1);
                acc[s] = r && iv;
                if (s == 0) begin
                    req0 = (nfr[0] > 0); axiiv0 = iv; axiid0 = d; last0 = l;
                end else begin
                    req1 = (nfr[1] > 0); axiiv1 = iv; axiid1 = d; last1 = l;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    int ncyc = 0, nvalid = 0, nabort = 0, last_v = 0;
    int stream[$];
    int order[$];
    int gaps[$];
    bit ab_v = 0, ab_g = 0, ab_r = 0;
    bit pg0 = 0, pg1 = 0;

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (grant0 && !pg0) begin order.push_back(0); gaps.push_back(ncyc - last_v); end
            if (grant1 && !pg1) begin order.push_back(1); gaps.push_back(ncyc - last_v); end
            pg0 = grant0;
            pg1 = grant1;
            if (axiov) begin
                nvalid++;
                stream.push_back(int'(axiod));
                last_v = ncyc;
            end
            if (abort) begin
                nabort++;
                ab_v = axiov;
                ab_g = grant0 | grant1;
                ab_r = ready0 | ready1;
            end
        end
    end

    task automatic clear_mon();
        nvalid = 0; nabort = 0;
        stream.delete(); order.delete(); gaps.delete();
    endtask

    task automatic wait_valid(input int target, input int budget, input string nm);
        int k = 0;
        while (nvalid < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (nvalid < target) chk({nm, "_timeout"}, nvalid, target);
    endtask

    task automatic wait_abort(input int budget, input string nm);
        int k = 0;
        while (nabort == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (nabort == 0) chk({nm, "_timeout"}, nabort, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    int t1_pay[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        int k;
        int bad;
        repeat (3) @(negedge clk);
        started = 1;
        chk("rst_grant0", grant0, 0);
        chk("rst_grant1", grant1, 0);
        chk("rst_axiov",  axiov,  0);
        chk("rst_axiod",  axiod,  0);
        chk("rst_ready0", ready0, 0);
        chk("rst_abort",  abort,  0);

        // 1: single source 0 frame of 8 dibits
        len[0] = 8; lastf[0] = 1; drop[0] = -1; nfr[0] = 1;
        repeat (2) @(negedge clk);
        clear_mon();
        rst = 0;
        k = 0;
        do begin @(negedge clk); k++; end while (!grant0 && k < 10);
        chk("t1_grant_latency", k, 1);
        wait_valid(40, 200, "t1");
        repeat (60) @(negedge clk);
        chk("t1_nvalid", nvalid, 40);
        bad = 0;
        for (int i = 0; i < 31; i++) if (stream.size() > i && stream[i] != 1) bad++;
        chk("t1_preamble_bad", bad, 0);
        if (stream.size() >= 40) begin
            chk("t1_sfd", stream[31], 3);
            for (int i = 0; i < 8; i++) chk("t1_payload", stream[32 + i], t1_pay[i]);
        end else chk("t1_stream_len", stream.size(), 40);
        chk("t1_abort", nabort, 0);

        // 2: simultaneous requests from reset, two 4-dibit frames each
        pulse_reset();
        clear_mon();
        len[0] = 4; len[1] = 4; lastf[0] = 1; lastf[1] = 1; drop[0] = -1; drop[1] = -1;
        nfr[0] = 2; nfr[1] = 2;
        wait_valid(144, 1000, "t2");
        repeat (60) @(negedge clk);
        chk("t2_frames", order.size(), 4);
        if (order.size() == 4) begin
            chk("t2_order0", order[0], 0);
            chk("t2_order1", order[1], 1);
            chk("t2_order2", order[2], 0);
            chk("t2_order3", order[3], 1);
            for (int i = 1; i < 4; i++) chk("t2_spacing", gaps[i], IFG + 1);
        end
        chk("t2_abort", nabort, 0);

        // 3: source 1 underrun at payload dibit 3
        clear_mon();
        len[1] = 8; drop[1] = 2; nfr[1] = 1;
        wait_abort(200, "t3");
        repeat (60) @(negedge clk);
        chk("t3_abort_count", nabort, 1);
        chk("t3_abort_axiov", ab_v, 0);
        chk("t3_abort_grant", ab_g, 0);
        chk("t3_nvalid", nvalid, PRE + 2);
        drop[1] = -1;

        // 4: watchdog truncation, 20 dibits without last
        clear_mon();
        len[0] = 20; lastf[0] = 0; nfr[0] = 1;
        wait_abort(300, "t4");
        repeat (60) @(negedge clk);
        chk("t4_nvalid", nvalid, PRE + MAXD);
        chk("t4_abort_count", nabort, 1);
        chk("t4_abort_with_last_dibit", ab_v, 1);
        chk("t4_ready_after", ab_r, 0);
        if (stream.size() == PRE + MAXD) chk("t4_last_forwarded", stream[PRE + MAXD - 1], (MAXD - 1 + 1) & 3);
        lastf[0] = 1;

        // 5: request arriving during the gap
        clear_mon();
        len[0] = 4; len[1] = 4; nfr[0] = 1;
        wait_valid(36, 200, "t5a");
        repeat (10) @(negedge clk);
        nfr[1] = 1;
        wait_valid(72, 300, "t5b");
        repeat (60) @(negedge clk);
        chk("t5_frames", order.size(), 2);
        if (order.size() == 2) begin
            chk("t5_second_src", order[1], 1);
            chk("t5_spacing", gaps[1], IFG + 1);
        end
        if (stream.size() == 72) chk("t5_sfd2", stream[36 + 31], 3);

        // 6: reset in the middle of a source 0 payload
        clear_mon();
        len[0] = 12; nfr[0] = 1;
        k = 0;
        while (!(grant0 && idx[0] >= 5) && k < 200) begin @(negedge clk); k++; end
        chk("t6_reached_dibit5", int'(idx[0] >= 5), 1);
        rst = 1;
        @(negedge clk);
        chk("t6_rst_axiov",  axiov,  0);
        chk("t6_rst_grant0", grant0, 0);
        chk("t6_rst_ready0", ready0, 0);
        chk("t6_rst_axiod",  axiod,  0);
        order.delete();
        len[0] = 4; len[1] = 4; nfr[0] = 1; nfr[1] = 1;
        @(negedge clk);
        rst = 0;
        k = 0;
        while (order.size() == 0 && k < 20) begin @(negedge clk); k++; end
        chk("t6_first_after_reset", (order.size() > 0) ? order[0] : -1, 0);
        k = 0;
        while (order.size() < 2 && k < 300) begin @(negedge clk); k++; end
        repeat (60) @(negedge clk);
        chk("t6_second_src", (order.size() > 1) ? order[1] : -1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
